// File: rtl/hpm_counter_bank_pkg.sv
// hpm_counter_bank_pkg
//   Shared constants for the HPM counter bank: XLEN, CSR address-space
//   select values, the IRQ-enable register address, the event numbering
//   used by software and the core top level, and a selector-width helper.
//   Optional feature macro used by the bank: HPM_OVERFLOW_IRQ_EN.
package hpm_counter_bank_pkg;

    localparam int unsigned XLEN            = 64;
    localparam int unsigned NR_COMMIT_PORTS = 2;

    // addr[5] selects between counter space and event-selector space
    localparam logic HPM_SEL_CTR = 1'b0;
    localparam logic HPM_SEL_EVT = 1'b1;

    localparam logic [5:0] HPM_IRQ_EN_ADDR = 6'h3F;

    // Selector value; selector s counts event_inc[s-1]
    typedef enum logic [7:0] {
        HPM_EVT_NONE         = 8'd0,
        HPM_EVT_ICACHE_MISS  = 8'd1,
        HPM_EVT_DCACHE_MISS  = 8'd2,
        HPM_EVT_ITLB_MISS    = 8'd3,
        HPM_EVT_DTLB_MISS    = 8'd4,
        HPM_EVT_LOAD         = 8'd5,
        HPM_EVT_STORE        = 8'd6,
        HPM_EVT_EXCEPTION    = 8'd7,
        HPM_EVT_EXC_RET      = 8'd8,
        HPM_EVT_BRANCH       = 8'd9,
        HPM_EVT_BRANCH_MISS  = 8'd10,
        HPM_EVT_CALL         = 8'd11,
        HPM_EVT_RET          = 8'd12,
        HPM_EVT_MSB_FULL     = 8'd13,
        HPM_EVT_IF_EMPTY     = 8'd14,
        HPM_EVT_COMMIT_LOAD  = 8'd15,
        HPM_EVT_COMMIT_STORE = 8'd16
    } hpm_event_e;

    function automatic int unsigned hpm_sel_width(input int unsigned num_events);
        return $clog2(num_events + 1);
    endfunction

endpackage

// File: rtl/hpm_counter.sv
// hpm_counter
//   One programmable performance counter: event selector, count register,
//   sticky overflow flag, event mux, adder and write-over-increment priority.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   count_en      counting allowed this cycle (not in debug, not inhibited)
//   cnt_we        write cnt_wdata to the count, clears ovf, drops increment
//   sel_we        write sel_wdata to the selector (counts from next cycle)
//   event_inc     flattened NumEvents x IncWidth increment vector
//   count, sel    current register values
//   ovf           sticky overflow flag
module hpm_counter
    import hpm_counter_bank_pkg::*;
#(
    parameter int unsigned NumEvents    = 16,
    parameter int unsigned CounterWidth = 48,
    parameter int unsigned IncWidth     = 2,
    parameter int unsigned SelWidth     = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          count_en,
    input  logic                          cnt_we,
    input  logic                          sel_we,
    input  logic [CounterWidth-1:0]       cnt_wdata,
    input  logic [SelWidth-1:0]           sel_wdata,
    input  logic [NumEvents*IncWidth-1:0] event_inc,
    output logic [CounterWidth-1:0]       count,
    output logic [SelWidth-1:0]           sel,
    output logic                          ovf
);

    logic [IncWidth-1:0]   inc;
    logic [CounterWidth:0] sum;

    // Selector 0 and selectors above NumEvents match nothing and stay idle
    always_comb begin
        inc = '0;
        for (int unsigned e = 0; e < NumEvents; e++) begin
            if (sel == SelWidth'(e + 1)) begin
                inc = event_inc[e*IncWidth +: IncWidth];
            end
        end
    end

    // Extra MSB captures the carry that marks a wrap
    assign sum = {1'b0, count} + (CounterWidth + 1)'(inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            sel   <= '0;
            ovf   <= 1'b0;
        end else begin
            if (cnt_we) begin
                count <= cnt_wdata;
                ovf   <= 1'b0;
            end else if (count_en) begin
                count <= sum[CounterWidth-1:0];
                if (sum[CounterWidth]) begin
                    ovf <= 1'b1;
                end
            end
            if (sel_we) begin
                sel <= sel_wdata;
            end
        end
    end

endmodule

// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank
//   Bank of NumCounters programmable HPM counters behind an SRAM-like CSR
//   port. Owns address decode, the combinational read mux, the optional
//   overflow-interrupt enable register and the registered irq output.
//   Optional feature: define HPM_OVERFLOW_IRQ_EN to add the IRQ-enable
//   register at 6'h3F and drive irq_o; otherwise irq_o is tied low.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   debug_mode_i   freezes all counting
//   addr_i         [5]=0 counter, [5]=1 selector; [4:0] index
//   we_i, data_i   write strobe and data
//   data_o         combinational read data
//   inhibit_i      per-counter inhibit
//   event_inc_i    flattened NumEvents x IncWidth increments
//   ovf_o          sticky overflow flags
//   irq_o          registered overflow interrupt
module hpm_counter_bank
    import hpm_counter_bank_pkg::*;
#(
    parameter int unsigned NumCounters  = 8,
    parameter int unsigned NumEvents    = 16,
    parameter int unsigned CounterWidth = 48,
    parameter int unsigned IncWidth     = $clog2(NR_COMMIT_PORTS + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          debug_mode_i,
    input  logic [5:0]                    addr_i,
    input  logic                          we_i,
    input  logic [XLEN-1:0]               data_i,
    output logic [XLEN-1:0]               data_o,
    input  logic [NumCounters-1:0]        inhibit_i,
    input  logic [NumEvents*IncWidth-1:0] event_inc_i,
    output logic [NumCounters-1:0]        ovf_o,
    output logic                          irq_o
);

    localparam int unsigned SelWidth = hpm_sel_width(NumEvents);

    logic [4:0]              idx;
    logic                    irq_en_hit;
    logic                    ctr_space;
    logic                    sel_space;
    logic [CounterWidth-1:0] count_q [NumCounters];
    logic [SelWidth-1:0]     sel_q   [NumCounters];
    logic                    unused_data;

    assign idx        = addr_i[4:0];
    assign irq_en_hit = (addr_i == HPM_IRQ_EN_ADDR);
    assign ctr_space  = (addr_i[5] == HPM_SEL_CTR);
    // 6'h3F always belongs to the IRQ-enable slot, even with 32 counters
    assign sel_space  = (addr_i[5] == HPM_SEL_EVT) && !irq_en_hit;

    assign unused_data = ^data_i;

    for (genvar k = 0; k < NumCounters; k++) begin : g_ctr
        hpm_counter #(
            .NumEvents   (NumEvents),
            .CounterWidth(CounterWidth),
            .IncWidth    (IncWidth),
            .SelWidth    (SelWidth)
        ) u_ctr (
            .clk      (clk_i),
            .rst      (rst_i),
            .count_en (!debug_mode_i && !inhibit_i[k]),
            .cnt_we   (we_i && ctr_space && (idx == 5'(k))),
            .sel_we   (we_i && sel_space && (idx == 5'(k))),
            .cnt_wdata(data_i[CounterWidth-1:0]),
            .sel_wdata(data_i[SelWidth-1:0]),
            .event_inc(event_inc_i),
            .count    (count_q[k]),
            .sel      (sel_q[k]),
            .ovf      (ovf_o[k])
        );
    end

`ifdef HPM_OVERFLOW_IRQ_EN
    logic [NumCounters-1:0] irq_en_q;
    logic                   irq_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (we_i && irq_en_hit) begin
                irq_en_q <= data_i[NumCounters-1:0];
            end
            irq_q <= |(ovf_o & irq_en_q);
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        data_o = '0;
        for (int unsigned k = 0; k < NumCounters; k++) begin
            if (idx == 5'(k)) begin
                if (ctr_space) begin
                    data_o = XLEN'(count_q[k]);
                end else if (sel_space) begin
                    data_o = XLEN'(sel_q[k]);
                end
            end
        end
`ifdef HPM_OVERFLOW_IRQ_EN
        if (irq_en_hit) begin
            data_o = XLEN'(irq_en_q);
        end
`endif
    end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb_hpm_counter_bank
//   Self-checking bench for hpm_counter_bank with default parameters.
//   A behavioural model (plain arrays and arithmetic) tracks counts,
//   selectors, overflow flags and the optional IRQ enable register.
`timescale 1ns/1ps
module tb_hpm_counter_bank;
    import hpm_counter_bank_pkg::*;

    localparam int unsigned NC = 8;
    localparam int unsigned NE = 16;
    localparam int unsigned CW = 48;
    localparam int unsigned IW = 2;
    localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                debug_mode_i;
    logic [5:0]          addr_i;
    logic                we_i;
    logic [XLEN-1:0]     data_i;
    logic [XLEN-1:0]     data_o;
    logic [NC-1:0]       inhibit_i;
    logic [NE*IW-1:0]    event_inc_i;
    logic [NC-1:0]       ovf_o;
    logic                irq_o;

    hpm_counter_bank #(
        .NumCounters (NC),
        .NumEvents   (NE),
        .CounterWidth(CW),
        .IncWidth    (IW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .debug_mode_i(debug_mode_i),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .inhibit_i   (inhibit_i),
        .event_inc_i (event_inc_i),
        .ovf_o       (ovf_o),
        .irq_o       (irq_o)
    );

    always #50 clk = ~clk;

    // stimulus for the next cycle
    bit              rst_s;
    bit              dbg_s;
    bit              we_s;
    bit [5:0]        addr_s;
    longint unsigned wdata_s;
    bit [NC-1:0]     inh_s;
    int unsigned     ev [NE];

    // reference model
    longint unsigned m_cnt [NC];
    int unsigned     m_sel [NC];
    bit              m_ovf [NC];
    longint unsigned m_en;
    bit              m_irq;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned exp_read(input bit [5:0] a);
        int unsigned idx;
        idx = int'(a[4:0]);
        if (a == 6'h3F) begin
`ifdef HPM_OVERFLOW_IRQ_EN
            return m_en;
`else
            return 64'd0;
`endif
        end
        if (idx >= NC) return 64'd0;
        return a[5] ? longint'(m_sel[idx]) : m_cnt[idx];
    endfunction

    // advance the model by one clock edge using the current stimulus
    task automatic model_step();
        bit              irq_next;
        longint unsigned inc;
        longint unsigned t;
        int unsigned     s;
        if (rst_s) begin
            for (int k = 0; k < NC; k++) begin
                m_cnt[k] = 0;
                m_sel[k] = 0;
                m_ovf[k] = 0;
            end
            m_en  = 0;
            m_irq = 0;
            return;
        end
        irq_next = 0;
`ifdef HPM_OVERFLOW_IRQ_EN
        for (int k = 0; k < NC; k++) if (m_ovf[k] && m_en[k]) irq_next = 1;
`endif
        for (int k = 0; k < NC; k++) begin
            s   = m_sel[k];
            inc = (s >= 1 && s <= NE) ? longint'(ev[s-1]) : 0;
            if (we_s && !addr_s[5] && int'(addr_s[4:0]) == k) begin
                m_cnt[k] = wdata_s & CMASK;
                m_ovf[k] = 0;
            end else if (!dbg_s && !inh_s[k]) begin
                t = m_cnt[k] + inc;
                if (t > CMASK) m_ovf[k] = 1;
                m_cnt[k] = t & CMASK;
            end
        end
        for (int k = 0; k < NC; k++) begin
            if (we_s && addr_s[5] && addr_s != 6'h3F && int'(addr_s[4:0]) == k)
                m_sel[k] = int'(wdata_s & 64'h1F);
        end
`ifdef HPM_OVERFLOW_IRQ_EN
        if (we_s && addr_s == 6'h3F) m_en = wdata_s & ((64'd1 << NC) - 64'd1);
`endif
        m_irq = irq_next;
    endtask

    task automatic step();
        rst_i        = rst_s;
        debug_mode_i = dbg_s;
        we_i         = we_s;
        addr_i       = addr_s;
        data_i       = wdata_s;
        inhibit_i    = inh_s;
        for (int e = 0; e < NE; e++) event_inc_i[e*IW +: IW] = IW'(ev[e]);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit [5:0] a, input longint unsigned d);
        we_s    = 1;
        addr_s  = a;
        wdata_s = d;
        step();
        we_s    = 0;
    endtask

    task automatic read_const(input string tag, input bit [5:0] a, input longint unsigned exp);
        we_i   = 0;
        addr_i = a;
        #1;
        check(tag, data_o, exp);
    endtask

    task automatic check_read(input bit [5:0] a);
        we_i   = 0;
        addr_i = a;
        #1;
        check($sformatf("rd_%02h", a), data_o, exp_read(a));
    endtask

    task automatic check_flags();
        logic [NC-1:0] e;
        for (int k = 0; k < NC; k++) e[k] = m_ovf[k];
        check("ovf", 64'(ovf_o), 64'(e));
        check("irq", 64'(irq_o), 64'(m_irq));
    endtask

    task automatic check_state();
        check_flags();
        for (int i = 0; i < 10; i++) begin
            check_read(6'(i));
            check_read(6'(i + 32));
        end
        check_read(6'h3F);
    endtask

    initial begin
        bit [5:0] a;
        rst_s = 1; dbg_s = 0; we_s = 0; addr_s = 0; wdata_s = 0; inh_s = '0;
        for (int e = 0; e < NE; e++) ev[e] = 0;
        m_en = 0; m_irq = 0;
        for (int k = 0; k < NC; k++) begin
            m_cnt[k] = 0; m_sel[k] = 0; m_ovf[k] = 0;
        end

        // reset then read everything
        step();
        rst_s = 0;
        check("rst_ovf", 64'(ovf_o), 64'd0);
        check("rst_irq", 64'(irq_o), 64'd0);
        check_state();

        // multi-increment on counter 0 via selector 3
        wr(6'h20, 3);
        ev[2] = 2;
        repeat (5) step();
        ev[2] = 0;
        read_const("multi_inc_ctr0", 6'h00, 10);
        read_const("multi_inc_ctr1", 6'h01, 0);
        check_state();

        // wrap and overflow on counter 1
        wr(6'h21, 1);
        ev[0] = 1;
        wr(6'h01, CMASK);
        read_const("wrap_preload", 6'h01, CMASK);
        step();
        read_const("wrap_count", 6'h01, 0);
        check("wrap_ovf1", 64'(ovf_o[1]), 64'd1);
        wr(6'h01, 5);
        read_const("wr_beats_inc", 6'h01, 5);
        check("wr_clears_ovf1", 64'(ovf_o[1]), 64'd0);
        ev[0] = 0;
        check_state();

        // freeze by debug mode, then by inhibit
        wr(6'h22, 2);
        ev[1] = 1;
        dbg_s = 1;
        repeat (10) step();
        read_const("debug_freeze", 6'h02, 0);
        dbg_s = 0;
        inh_s[2] = 1;
        repeat (10) step();
        read_const("inhibit_freeze", 6'h02, 0);
        inh_s = '0;
        step();
        read_const("resume", 6'h02, 1);
        ev[1] = 0;
        check_state();

        // overflow interrupt path
        wr(6'h3F, 2);
        wr(6'h01, CMASK);
        ev[0] = 1;
        step();
        ev[0] = 0;
        check("irq_ovf1", 64'(ovf_o[1]), 64'd1);
        check("irq_t1", 64'(irq_o), 64'd0);
        step();
`ifdef HPM_OVERFLOW_IRQ_EN
        check("irq_t2", 64'(irq_o), 64'd1);
        read_const("irq_en_rd", 6'h3F, 2);
`else
        check("irq_t2", 64'(irq_o), 64'd0);
        read_const("irq_en_rd", 6'h3F, 0);
`endif
        wr(6'h3F, 0);
`ifdef HPM_OVERFLOW_IRQ_EN
        check("irq_hold", 64'(irq_o), 64'd1);
`else
        check("irq_hold", 64'(irq_o), 64'd0);
`endif
        step();
        check("irq_drop", 64'(irq_o), 64'd0);
        check_state();

        // out-of-range selector and out-of-range index
        wr(6'h23, 30);
        for (int e = 0; e < NE; e++) ev[e] = 2;
        repeat (4) step();
        read_const("sel_oor_rd", 6'h23, 30);
        read_const("sel_oor_idle", 6'h03, 0);
        wr(6'h09, 64'h1234);
        wr(6'h29, 3);
        read_const("idx9_ctr", 6'h09, 0);
        read_const("idx9_sel", 6'h29, 0);
        for (int e = 0; e < NE; e++) ev[e] = 0;
        check_state();

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst_s = ($urandom_range(0, 149) == 0);
            dbg_s = ($urandom_range(0, 9) == 0);
            inh_s = NC'($urandom & $urandom & $urandom);
            we_s  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0, 1: begin
                    addr_s  = 6'($urandom_range(0, 9));
                    wdata_s = $urandom_range(0, 1) ? (CMASK - longint'($urandom_range(0, 6)))
                                                   : {$urandom, $urandom};
                end
                2, 3: begin
                    addr_s  = 6'(32 + $urandom_range(0, 9));
                    wdata_s = {$urandom, 27'd0, 5'($urandom_range(0, 19))};
                end
                default: begin
                    addr_s  = 6'h3F;
                    wdata_s = {$urandom, $urandom};
                end
            endcase
            for (int e = 0; e < NE; e++) ev[e] = $urandom_range(0, 2);
            step();
            check_flags();
            a = $urandom_range(0, 1) ? 6'($urandom_range(0, 9)) : 6'(32 + $urandom_range(0, 9));
            check_read(a);
        end
        rst_s = 0; we_s = 0; dbg_s = 0; inh_s = '0;
        step();
        check_state();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
